// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   DEF_REG_W   : default register index width
//   DEF_MC_LAT  : default multicycle EX occupancy in cycles
//   fetch_state_e : outstanding-fetch tracker states
package pipe_ctrl_pkg;

    localparam int unsigned DEF_REG_W  = 5;
    localparam int unsigned DEF_MC_LAT = 4;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_KILL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pipe_ctrl_fetch_tracker.sv
// Tracks one outstanding instruction fetch so that a fetch issued before a
// redirect is dropped when its data finally returns.
//   clk, rst      : clock, synchronous active-high reset
//   ic_req        : IF issues a fetch this cycle
//   ic_ack        : fetch data valid this cycle
//   redirect_eff  : a redirect actually takes effect this cycle
//   state         : current tracker state
//   if_discard    : drop the fetch data acked this cycle
module pipe_ctrl_fetch_tracker
    import pipe_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ic_req,
    input  logic         ic_ack,
    input  logic         redirect_eff,
    output fetch_state_e state,
    output logic         if_discard
);

    fetch_state_e state_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and discard
    always_comb begin
        state_nxt  = state;
        if_discard = 1'b0;
        case (state)
            FS_IDLE: begin
                // A fetch issued in the redirect cycle targets the old path
                if (ic_req && !ic_ack) begin
                    state_nxt = redirect_eff ? FS_KILL : FS_WAIT;
                end
            end
            FS_WAIT: begin
                // An ack coinciding with a redirect is flushed by ifid_clear
                if (ic_ack) begin
                    state_nxt = FS_IDLE;
                end else if (redirect_eff) begin
                    state_nxt = FS_KILL;
                end
            end
            FS_KILL: begin
                if (ic_ack) begin
                    if_discard = !rst;
                    state_nxt  = FS_IDLE;
                end
            end
            default: state_nxt = FS_IDLE;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline. Produces hold/clear
// for each pipeline register boundary plus the PC hold, under the fixed
// priority mem-wait > multicycle > redirect > load-use > fetch-wait.
//   clk, rst                 : clock, synchronous active-high reset
//   ic_req, ic_ack           : instruction fetch request / data valid
//   dm_req, dm_ack           : MEM access pending / completes
//   id_rs1/2, id_rs1/2_en    : ID source indices and read enables
//   ex_load, ex_rd           : EX holds a load, EX destination
//   ex_mc                    : EX holds a multicycle op
//   ex_redirect              : EX resolved a taken branch/jump
//   pc_hold, *_hold, *_clear : pipeline control (combinational)
//   if_discard               : drop fetch data acked this cycle
//   mc_busy                  : multicycle counter active
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W  = DEF_REG_W,
    parameter int unsigned MC_LAT = DEF_MC_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ic_req,
    input  logic             ic_ack,
    input  logic             dm_req,
    input  logic             dm_ack,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_en,
    input  logic             id_rs2_en,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mc,
    input  logic             ex_redirect,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_clear,
    output logic             idex_hold,
    output logic             idex_clear,
    output logic             exmem_hold,
    output logic             exmem_clear,
    output logic             memwb_hold,
    output logic             memwb_clear,
    output logic             if_discard,
    output logic             mc_busy
);

    localparam int unsigned MC_CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam logic [MC_CNT_W-1:0] MC_LAST = MC_CNT_W'(MC_LAT - 1);

    logic [MC_CNT_W-1:0] mc_cnt;
    fetch_state_e        fstate;
    logic                mem_stall;
    logic                mc_stall;
    logic                lu_haz;
    logic                f_stall;
    logic                redirect_eff;
    logic                discard;

    // Hazard terms
    assign mem_stall    = dm_req && !dm_ack;
    assign mc_stall     = ex_mc && (mc_cnt != MC_LAST);
    assign lu_haz       = ex_load && (ex_rd != '0) &&
                          ((id_rs1_en && (id_rs1 == ex_rd)) ||
                           (id_rs2_en && (id_rs2 == ex_rd)));
    assign f_stall      = ((fstate == FS_WAIT) || (fstate == FS_KILL) || ic_req) && !ic_ack;
    // A redirect under a mem/multicycle stall is ignored; EX re-presents it
    assign redirect_eff = ex_redirect && !mem_stall && !mc_stall && !rst;

    // Multicycle occupancy counter; frozen while MEM stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_cnt <= '0;
        end else if (!mem_stall) begin
            if (mc_cnt == MC_LAST) begin
                mc_cnt <= '0;
            end else if (ex_mc) begin
                mc_cnt <= mc_cnt + MC_CNT_W'(1);
            end
        end
    end

    pipe_ctrl_fetch_tracker u_fetch_tracker (
        .clk          (clk),
        .rst          (rst),
        .ic_req       (ic_req),
        .ic_ack       (ic_ack),
        .redirect_eff (redirect_eff),
        .state        (fstate),
        .if_discard   (discard)
    );

    // Priority resolution; only the winning rule drives hold/clear
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_clear  = 1'b0;
        idex_hold   = 1'b0;
        idex_clear  = 1'b0;
        exmem_hold  = 1'b0;
        exmem_clear = 1'b0;
        memwb_hold  = 1'b0;
        memwb_clear = 1'b0;
        if_discard  = 1'b0;
        mc_busy     = 1'b0;
        if (rst) begin
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
            exmem_clear = 1'b1;
            memwb_clear = 1'b1;
        end else begin
            mc_busy = (mc_cnt != '0);
            if (mem_stall) begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_hold   = 1'b1;
                exmem_hold  = 1'b1;
                memwb_clear = 1'b1;
            end else if (mc_stall) begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_hold   = 1'b1;
                exmem_clear = 1'b1;
            end else if (redirect_eff) begin
                ifid_clear = 1'b1;
                idex_clear = 1'b1;
            end else if (lu_haz) begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_clear = 1'b1;
            end else if (f_stall) begin
                pc_hold    = 1'b1;
                ifid_clear = 1'b1;
            end
            // Redirect target already latched in PC; keep it until the stale fetch returns
            if (fstate == FS_KILL) begin
                pc_hold = 1'b1;
            end
            if (discard) begin
                if_discard = 1'b1;
                ifid_clear = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: single-cycle vector table plus
// hand-written multi-cycle sequences, checked through an expectation queue.
module tb_pipe_ctrl;

    localparam int unsigned REG_W = 5;

    // Expected-output bit positions
    localparam logic [10:0] E_PC   = 11'h400;
    localparam logic [10:0] E_IFH  = 11'h200;
    localparam logic [10:0] E_IFC  = 11'h100;
    localparam logic [10:0] E_IDH  = 11'h080;
    localparam logic [10:0] E_IDC  = 11'h040;
    localparam logic [10:0] E_EMH  = 11'h020;
    localparam logic [10:0] E_EMC  = 11'h010;
    localparam logic [10:0] E_MWH  = 11'h008;
    localparam logic [10:0] E_MWC  = 11'h004;
    localparam logic [10:0] E_DIS  = 11'h002;
    localparam logic [10:0] E_BUSY = 11'h001;

    localparam logic [10:0] MC_ST  = E_PC | E_IFH | E_IDH | E_EMC;
    localparam logic [10:0] MEM_ST = E_PC | E_IFH | E_IDH | E_EMH | E_MWC;
    localparam logic [10:0] LU_ST  = E_PC | E_IFH | E_IDC;
    localparam logic [10:0] RD_FL  = E_IFC | E_IDC;
    localparam logic [10:0] F_ST   = E_PC | E_IFC;
    localparam logic [10:0] RST_O  = E_IFC | E_IDC | E_EMC | E_MWC;

    typedef struct packed {
        logic             rst;
        logic             ic_req;
        logic             ic_ack;
        logic             dm_req;
        logic             dm_ack;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             rs1_en;
        logic             rs2_en;
        logic             ex_load;
        logic [REG_W-1:0] ex_rd;
        logic             ex_mc;
        logic             ex_redirect;
    } in_t;

    typedef struct {
        string       name;
        in_t         in;
        logic [10:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } sb_t;

    logic             clk = 1'b0;
    logic             rst, ic_req, ic_ack, dm_req, dm_ack;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_rs1_en, id_rs2_en, ex_load, ex_mc, ex_redirect;
    logic             pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear;
    logic             exmem_hold, exmem_clear, memwb_hold, memwb_clear;
    logic             if_discard, mc_busy;

    int checks = 0;
    int errors = 0;
    vec_t table_q[$];
    sb_t  sb_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_W(REG_W), .MC_LAT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ic_req      (ic_req),
        .ic_ack      (ic_ack),
        .dm_req      (dm_req),
        .dm_ack      (dm_ack),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_en   (id_rs1_en),
        .id_rs2_en   (id_rs2_en),
        .ex_load     (ex_load),
        .ex_rd       (ex_rd),
        .ex_mc       (ex_mc),
        .ex_redirect (ex_redirect),
        .pc_hold     (pc_hold),
        .ifid_hold   (ifid_hold),
        .ifid_clear  (ifid_clear),
        .idex_hold   (idex_hold),
        .idex_clear  (idex_clear),
        .exmem_hold  (exmem_hold),
        .exmem_clear (exmem_clear),
        .memwb_hold  (memwb_hold),
        .memwb_clear (memwb_clear),
        .if_discard  (if_discard),
        .mc_busy     (mc_busy)
    );

    task automatic drive(input in_t i);
        rst         = i.rst;
        ic_req      = i.ic_req;
        ic_ack      = i.ic_ack;
        dm_req      = i.dm_req;
        dm_ack      = i.dm_ack;
        id_rs1      = i.rs1;
        id_rs2      = i.rs2;
        id_rs1_en   = i.rs1_en;
        id_rs2_en   = i.rs2_en;
        ex_load     = i.ex_load;
        ex_rd       = i.ex_rd;
        ex_mc       = i.ex_mc;
        ex_redirect = i.ex_redirect;
    endtask

    // One cycle: drive after the rising edge, queue the expectation,
    // compare on the falling edge.
    task automatic step(input string name, input in_t i, input logic [10:0] exp);
        sb_t e;
        sb_t got;
        logic [10:0] act;
        @(posedge clk);
        #1;
        drive(i);
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        @(negedge clk);
        act = {pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
               exmem_hold, exmem_clear, memwb_hold, memwb_clear, if_discard, mc_busy};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            got = sb_q.pop_front();
            if (act !== got.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b (pc ifh ifc idh idc emh emc mwh mwc dis busy)",
                         got.name, act, got.exp);
            end
        end
    endtask

    task automatic add(input string name, input in_t i, input logic [10:0] exp);
        vec_t v;
        v.name = name;
        v.in   = i;
        v.exp  = exp;
        table_q.push_back(v);
    endtask

    initial begin
        in_t t;
        in_t z;
        z = '0;
        drive(z);

        // ---- single-cycle table (tracker idle, counter at 0) ----
        add("idle", z, 11'h0);
        t = z; t.ex_load = 1; t.ex_rd = 5; t.rs1 = 5; t.rs1_en = 1;
        add("lu_rs1", t, LU_ST);
        t = z; t.ex_load = 1; t.ex_rd = 0; t.rs1 = 0; t.rs1_en = 1;
        add("lu_rd0", t, 11'h0);
        t = z; t.ex_load = 1; t.ex_rd = 7; t.rs2 = 7; t.rs2_en = 1; t.rs1 = 3; t.rs1_en = 1;
        add("lu_rs2", t, LU_ST);
        t = z; t.ex_load = 1; t.ex_rd = 7; t.rs1 = 7; t.rs2 = 7;
        add("lu_no_en", t, 11'h0);
        t = z; t.ex_rd = 5; t.rs1 = 5; t.rs1_en = 1;
        add("lu_not_load", t, 11'h0);
        t = z; t.dm_req = 1;
        add("mem_stall", t, MEM_ST);
        t = z; t.dm_req = 1; t.dm_ack = 1;
        add("mem_done", t, 11'h0);
        t = z; t.ex_redirect = 1;
        add("redirect", t, RD_FL);
        t = z; t.ex_redirect = 1; t.ex_load = 1; t.ex_rd = 9; t.rs1 = 9; t.rs1_en = 1;
        add("redirect_over_lu", t, RD_FL);
        t = z; t.ex_redirect = 1; t.dm_req = 1;
        add("mem_over_redirect", t, MEM_ST);
        t = z; t.ic_req = 1; t.ic_ack = 1;
        add("fetch_hit", t, 11'h0);
        t = z; t.ic_ack = 1;
        add("idle_ack_no_discard", t, 11'h0);

        // reset state
        t = z; t.rst = 1;
        step("reset", t, RST_O);

        foreach (table_q[k]) step(table_q[k].name, table_q[k].in, table_q[k].exp);

        // ---- multicycle, two back-to-back ops ----
        t = z; t.ex_mc = 1;
        for (int op = 0; op < 2; op++) begin
            step("mc_c1", t, MC_ST);
            step("mc_c2", t, MC_ST | E_BUSY);
            step("mc_c3", t, MC_ST | E_BUSY);
            step("mc_c4", t, E_BUSY);
        end
        step("mc_after", z, 11'h0);

        // ---- memory stall over multicycle: count frozen at 1 ----
        t = z; t.ex_mc = 1;
        step("mcm_c1", t, MC_ST);
        t.dm_req = 1;
        for (int k = 0; k < 3; k++) step("mcm_memstall", t, MEM_ST | E_BUSY);
        t.dm_ack = 1;
        step("mcm_cnt1", t, MC_ST | E_BUSY);
        t = z; t.ex_mc = 1;
        step("mcm_cnt2", t, MC_ST | E_BUSY);
        step("mcm_cnt3", t, E_BUSY);
        step("mcm_after", z, 11'h0);

        // ---- redirect with fetch outstanding ----
        t = z; t.ic_req = 1;
        step("rk_req", t, F_ST);
        t = z; t.ex_redirect = 1;
        step("rk_redirect", t, RD_FL);
        step("rk_kill3", z, F_ST);
        step("rk_kill4", z, F_ST);
        t = z; t.ic_ack = 1;
        step("rk_discard", t, F_ST | E_DIS);
        t = z; t.ic_req = 1; t.ic_ack = 1;
        step("rk_idle", t, 11'h0);

        // ---- fetch issued in the redirect cycle is stale ----
        t = z; t.ic_req = 1; t.ex_redirect = 1;
        step("ri_req_redirect", t, RD_FL);
        step("ri_kill", z, F_ST);
        t = z; t.ic_ack = 1;
        step("ri_discard", t, F_ST | E_DIS);
        step("ri_idle", z, 11'h0);

        // ---- ack in WAIT with redirect returns to idle ----
        t = z; t.ic_req = 1;
        step("wa_req", t, F_ST);
        t = z; t.ic_ack = 1; t.ex_redirect = 1;
        step("wa_ack_redirect", t, RD_FL);
        t = z; t.ic_ack = 1;
        step("wa_no_discard", t, 11'h0);

        // ---- redirect ignored under multicycle stall ----
        t = z; t.ex_mc = 1; t.ex_redirect = 1;
        step("mcr_c1", t, MC_ST);
        t = z; t.ex_mc = 1; t.ic_req = 1;
        step("mcr_c2", t, MC_ST | E_BUSY);
        step("mcr_c3", t, MC_ST | E_BUSY);
        t = z; t.ex_mc = 1; t.ex_redirect = 1; t.ic_req = 1; t.ic_ack = 1;
        step("mcr_c4_redirect", t, RD_FL | E_BUSY);
        step("mcr_after", z, 11'h0);

        // ---- reset in KILL ----
        t = z; t.ic_req = 1;
        step("rsk_req", t, F_ST);
        t = z; t.ex_redirect = 1;
        step("rsk_redirect", t, RD_FL);
        step("rsk_kill", z, F_ST);
        t = z; t.rst = 1;
        step("rsk_reset", t, RST_O);
        t = z; t.ic_ack = 1;
        step("rsk_ack_after", t, 11'h0);

        // ---- reset mid multicycle clears the counter ----
        t = z; t.ex_mc = 1;
        step("rsm_c1", t, MC_ST);
        step("rsm_c2", t, MC_ST | E_BUSY);
        t.rst = 1;
        step("rsm_reset", t, RST_O);
        step("rsm_after", z, 11'h0);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
